// File: rtl/dvp_rgb444_capture.sv
// DVP camera capture: pairs RGB565 bytes into RGB444 pixels, skips settling frames
// after reset and crops each frame to IMAGE_SIZE_H x IMAGE_SIZE_V.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_SKIP   | discarding settling frames, counting vsync pulse starts
// ST_WAIT   | between frames, waiting for the vsync pulse to end
// ST_ACTIVE | inside a frame, pairing bytes into pixels
module dvp_rgb444_capture #(
    parameter int IMAGE_SIZE_H   = 512,
    parameter int IMAGE_SIZE_V   = 384,
    parameter int FRAME_SKIP     = 10,
    parameter int VSYNC_ACT_HIGH = 1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_cam_vsync,
    input  logic        i_cam_href,
    input  logic [7:0]  i_cam_data,
    output logic        o_rgb565_vde,
    output logic        o_rgb565_vsync,
    output logic [11:0] o_rgb565_data,
    output logic        o_frame_done,
    output logic        o_byte_err
);

    typedef enum logic [1:0] {ST_SKIP, ST_WAIT, ST_ACTIVE} state_t;

    localparam logic [10:0] H_LIM   = 11'(IMAGE_SIZE_H);
    localparam logic [10:0] V_LIM   = 11'(IMAGE_SIZE_V);
    localparam logic [7:0]  SKIP_N  = 8'(FRAME_SKIP);
    localparam logic        VS_POL  = (VSYNC_ACT_HIGH != 0);
    localparam logic [9:0]  CNT_MAX = 10'h3FF;

    state_t      state_q, state_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  data_q, data_d;
    logic        vs_prev_q, vs_prev_d;
    logic        href_prev_q, href_prev_d;
    logic [7:0]  skip_q, skip_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic        pix_vld_q, pix_vld_d;
    logic [11:0] pix_q, pix_d;
    logic        vde_q, vde_d;
    logic [11:0] rgb_q, rgb_d;
    logic        vs_out_q, vs_out_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic vs_act, vs_rise, vs_fall, href_fall, in_window;

    assign vs_act    = ~(vsync_q ^ VS_POL);
    assign vs_rise   = vs_act & ~vs_prev_q;
    assign vs_fall   = ~vs_act & vs_prev_q;
    assign href_fall = ~href_q & href_prev_q;
    assign in_window = ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);

    always_comb begin
        vsync_d     = i_cam_vsync;
        href_d      = i_cam_href;
        data_d      = i_cam_data;
        vs_prev_d   = vs_act;
        href_prev_d = href_q;
        state_d     = state_q;
        skip_d      = skip_q;
        x_d         = x_q;
        y_d         = y_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        pix_vld_d   = 1'b0;
        pix_d       = pix_q;
        vde_d       = pix_vld_q;
        rgb_d       = pix_vld_q ? pix_q : rgb_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_SKIP: begin
                if (skip_q == SKIP_N) begin
                    state_d = ST_WAIT;
                end else if (vs_rise) begin
                    skip_d = skip_q + 8'd1;
                end
            end
            ST_WAIT: begin
                if (vs_fall) begin
                    state_d = ST_ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                // vsync start closes the frame and takes priority over any byte
                if (vs_rise) begin
                    state_d = ST_WAIT;
                    done_d  = 1'b1;
                    phase_d = 1'b0;
                end else if (href_q) begin
                    if (!phase_q) begin
                        hi_d    = data_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (in_window) begin
                            pix_vld_d = 1'b1;
                            pix_d     = {hi_q[7:4], hi_q[2:0], data_q[7], data_q[4:1]};
                        end
                        if (x_q != CNT_MAX) begin
                            x_d = x_q + 10'd1;
                        end
                    end
                end else if (href_fall) begin
                    if (x_q != '0 && y_q != CNT_MAX) begin
                        y_d = y_q + 10'd1;
                    end
                    x_d     = '0;
                    err_d   = phase_q;
                    phase_d = 1'b0;
                end
            end
            default: state_d = ST_SKIP;
        endcase

        vs_out_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            // vsync register starts at its inactive level so no edge is seen out of reset
            vsync_q     <= ~VS_POL;
            href_q      <= 1'b0;
            data_q      <= '0;
            vs_prev_q   <= 1'b0;
            href_prev_q <= 1'b0;
            state_q     <= ST_SKIP;
            skip_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            pix_vld_q   <= 1'b0;
            pix_q       <= '0;
            vde_q       <= 1'b0;
            rgb_q       <= '0;
            vs_out_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            vs_prev_q   <= vs_prev_d;
            href_prev_q <= href_prev_d;
            state_q     <= state_d;
            skip_q      <= skip_d;
            x_q         <= x_d;
            y_q         <= y_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            pix_vld_q   <= pix_vld_d;
            pix_q       <= pix_d;
            vde_q       <= vde_d;
            rgb_q       <= rgb_d;
            vs_out_q    <= vs_out_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign o_rgb565_vde   = vde_q;
    assign o_rgb565_vsync = vs_out_q;
    assign o_rgb565_data  = rgb_q;
    assign o_frame_done   = done_q;
    assign o_byte_err     = err_q;

endmodule
